// File: rtl/ssemi_adc_decimator_cfg_sequencer_if.sv
// Handshake bundle between the coefficient sequencer, its coefficient source and the decimator config port.
// A word moves on a rising clock edge only when valid and ready are both high; the side raising valid holds its payload stable until that edge.
interface ssemi_adc_decimator_cfg_sequencer_if #(
  parameter int COEFF_WIDTH = 18
);
  logic                   coeff_valid;
  logic [COEFF_WIDTH-1:0] coeff_data;
  logic                   coeff_ready;
  logic                   cfg_valid;
  logic [7:0]             cfg_addr;
  logic [31:0]            cfg_data;
  logic                   cfg_ready;

  modport master (
    input  coeff_valid, coeff_data, cfg_ready,
    output coeff_ready, cfg_valid, cfg_addr, cfg_data
  );

  modport slave (
    output coeff_valid, coeff_data, cfg_ready,
    input  coeff_ready, cfg_valid, cfg_addr, cfg_data
  );
endinterface

// File: rtl/ssemi_adc_decimator_cfg_sequencer.sv
// Loads a range of FIR or halfband coefficients into the decimator config port, one word at a time,
// with command range checking, the halfband zero-tap rule, a per-write timeout and abort.
module ssemi_adc_decimator_cfg_sequencer #(
  parameter int FIR_TAPS       = 64,
  parameter int HALFBAND_TAPS  = 33,
  parameter int HB_BASE_ADDR   = 64,
  parameter int COEFF_WIDTH    = 18,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_start,
  input  logic                                  i_abort,
  input  logic                                  i_sel_halfband,
  input  logic [7:0]                            i_base_idx,
  input  logic [7:0]                            i_count,
  ssemi_adc_decimator_cfg_sequencer_if.master   bus,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_error,
  output logic [2:0]                            o_error_type,
  output logic [7:0]                            o_words_written,
  output logic [2:0]                            o_state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_FETCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  localparam logic [2:0] ERR_RANGE   = 3'b001;
  localparam logic [2:0] ERR_TIMEOUT = 3'b010;
  localparam logic [2:0] ERR_SYM     = 3'b011;
  localparam logic [2:0] ERR_ABORT   = 3'b100;

  localparam int              WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]      FIR_SIZE  = 9'(FIR_TAPS);
  localparam logic [8:0]      HB_SIZE   = 9'(HALFBAND_TAPS);
  localparam logic [7:0]      HB_CENTER = 8'((HALFBAND_TAPS - 1) / 2);
  localparam logic [7:0]      HB_BASE   = 8'(HB_BASE_ADDR);

  state_e              state_q;
  logic                sel_hb_q;
  logic [7:0]          base_q;
  logic [7:0]          count_q;
  logic [7:0]          offset_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                coeff_ready_q;
  logic                cfg_valid_q;
  logic [7:0]          cfg_addr_q;
  logic [31:0]         cfg_data_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [2:0]          err_type_q;
  logic [7:0]          words_q;

  logic [8:0]          range_end;
  logic                range_bad;
  logic [7:0]          abs_idx;
  logic                sym_bad;
  logic                src_xfer;
  logic                cfg_xfer;
  logic                last_word;
  logic                err_hit;
  logic [2:0]          err_code;

  // Range is evaluated one bit wider than the operands so base+count cannot wrap past the bank end.
  assign range_end = {1'b0, base_q} + {1'b0, count_q};
  assign range_bad = (count_q == 8'd0) || (range_end > (sel_hb_q ? HB_SIZE : FIR_SIZE));
  assign abs_idx   = base_q + offset_q;
  assign sym_bad   = sel_hb_q && abs_idx[0] && (abs_idx != HB_CENTER) &&
                     (bus.coeff_data != '0);
  assign src_xfer  = coeff_ready_q && bus.coeff_valid;
  assign cfg_xfer  = cfg_valid_q && bus.cfg_ready;
  assign last_word = (offset_q + 8'd1) == count_q;

  // Only one error source can be live per state; abort always wins.
  always_comb begin
    err_hit  = 1'b0;
    err_code = 3'b000;
    case (state_q)
      S_CHECK: begin
        if (i_abort) begin
          err_hit  = 1'b1;
          err_code = ERR_ABORT;
        end else if (range_bad) begin
          err_hit  = 1'b1;
          err_code = ERR_RANGE;
        end
      end
      S_FETCH: begin
        if (i_abort) begin
          err_hit  = 1'b1;
          err_code = ERR_ABORT;
        end else if (src_xfer && sym_bad) begin
          err_hit  = 1'b1;
          err_code = ERR_SYM;
        end
      end
      S_WRITE: begin
        if (i_abort) begin
          err_hit  = 1'b1;
          err_code = ERR_ABORT;
        end else if (!bus.cfg_ready && (wait_q == WAIT_LAST)) begin
          err_hit  = 1'b1;
          err_code = ERR_TIMEOUT;
        end
      end
      default: begin
        err_hit  = 1'b0;
        err_code = 3'b000;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      sel_hb_q      <= 1'b0;
      base_q        <= 8'd0;
      count_q       <= 8'd0;
      offset_q      <= 8'd0;
      wait_q        <= '0;
      coeff_ready_q <= 1'b0;
      cfg_valid_q   <= 1'b0;
      cfg_addr_q    <= 8'd0;
      cfg_data_q    <= 32'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_type_q    <= 3'b000;
      words_q       <= 8'd0;
    end else begin
      done_q <= 1'b0;
      // A write accepted alongside an abort still landed in the decimator, so it is counted.
      if ((state_q == S_WRITE) && cfg_xfer) begin
        words_q  <= words_q + 8'd1;
        offset_q <= offset_q + 8'd1;
      end
      if (err_hit) begin
        state_q       <= S_ERR;
        error_q       <= 1'b1;
        err_type_q    <= err_code;
        busy_q        <= 1'b0;
        cfg_valid_q   <= 1'b0;
        coeff_ready_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_start) begin
              sel_hb_q   <= i_sel_halfband;
              base_q     <= i_base_idx;
              count_q    <= i_count;
              offset_q   <= 8'd0;
              error_q    <= 1'b0;
              err_type_q <= 3'b000;
              words_q    <= 8'd0;
              busy_q     <= 1'b1;
              state_q    <= S_CHECK;
            end
          end
          S_CHECK: begin
            coeff_ready_q <= 1'b1;
            state_q       <= S_FETCH;
          end
          S_FETCH: begin
            if (src_xfer) begin
              coeff_ready_q <= 1'b0;
              cfg_valid_q   <= 1'b1;
              cfg_addr_q    <= sel_hb_q ? (HB_BASE + abs_idx) : abs_idx;
              cfg_data_q    <= {{(32 - COEFF_WIDTH){bus.coeff_data[COEFF_WIDTH-1]}},
                                bus.coeff_data};
              wait_q        <= '0;
              state_q       <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (cfg_xfer) begin
              cfg_valid_q <= 1'b0;
              if (last_word) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end else begin
                coeff_ready_q <= 1'b1;
                state_q       <= S_FETCH;
              end
            end else begin
              wait_q <= wait_q + WAIT_W'(1);
            end
          end
          S_DONE:  state_q <= S_IDLE;
          S_ERR:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.coeff_ready = coeff_ready_q;
  assign bus.cfg_valid   = cfg_valid_q;
  assign bus.cfg_addr    = cfg_addr_q;
  assign bus.cfg_data    = cfg_data_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_error         = error_q;
  assign o_error_type    = err_type_q;
  assign o_words_written = words_q;
  assign o_state_dbg     = state_q;

endmodule

// File: tb/tb_ssemi_adc_decimator_cfg_sequencer.sv
// Directed bench for the coefficient sequencer: a load-level model predicts writes, outcome and timing per command.
module tb_ssemi_adc_decimator_cfg_sequencer;
  localparam int FIR_TAPS = 64;
  localparam int HB_TAPS  = 33;
  localparam int HB_BASE  = 64;
  localparam int CW       = 18;
  localparam int TO       = 255;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start    = 1'b0;
  logic       abort    = 1'b0;
  logic       sel_hb   = 1'b0;
  logic [7:0] base_idx = 8'd0;
  logic [7:0] count    = 8'd0;
  logic       busy, done, error;
  logic [2:0] error_type, state_dbg;
  logic [7:0] words_written;

  ssemi_adc_decimator_cfg_sequencer_if #(.COEFF_WIDTH(CW)) bus_if ();

  ssemi_adc_decimator_cfg_sequencer #(
    .FIR_TAPS(FIR_TAPS), .HALFBAND_TAPS(HB_TAPS), .HB_BASE_ADDR(HB_BASE),
    .COEFF_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_sel_halfband(sel_hb), .i_base_idx(base_idx), .i_count(count),
    .bus(bus_if), .o_busy(busy), .o_done(done), .o_error(error),
    .o_error_type(error_type), .o_words_written(words_written), .o_state_dbg(state_dbg)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;
  int end_cyc = 0;
  int valid_cycles = 0;
  int first_valid_cyc = -1;
  int done_count = 0;
  logic src_take = 1'b0;
  logic prev_stall = 1'b0;
  logic [39:0] prev_bus = 40'd0;

  logic [39:0]          exp_q[$];
  logic [CW-1:0]        src_q[$];
  logic signed [CW-1:0] src_words[256];
  int exp_code, exp_words, exp_lat;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- source driver ----------------
  initial begin
    bus_if.coeff_valid = 1'b0;
    bus_if.coeff_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (src_take && (src_q.size() > 0)) void'(src_q.pop_front());
      bus_if.coeff_valid = (src_q.size() > 0);
      bus_if.coeff_data  = (src_q.size() > 0) ? src_q[0] : '0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial forever begin
    @(negedge clk);
    src_take = bus_if.coeff_valid && bus_if.coeff_ready;
    if (bus_if.cfg_valid) begin
      valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (done) done_count++;
    if (prev_stall && bus_if.cfg_valid)
      check("cfg_hold", {bus_if.cfg_addr, bus_if.cfg_data}, prev_bus);
    if (bus_if.cfg_valid && bus_if.cfg_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cfg_unexpected: got write addr %0d data %0h expected none", bus_if.cfg_addr, bus_if.cfg_data);
      end else begin
        check("cfg_write", {bus_if.cfg_addr, bus_if.cfg_data}, exp_q.pop_front());
      end
    end
    prev_stall = bus_if.cfg_valid && !bus_if.cfg_ready;
    prev_bus   = {bus_if.cfg_addr, bus_if.cfg_data};
  end

  // ---------------- load-level model ----------------
  task automatic model_load(input logic hb, input int b, input int c, input logic stall);
    int size;
    int idx;
    logic [7:0]  addr;
    logic [31:0] sx;
    size = hb ? HB_TAPS : FIR_TAPS;
    exp_q.delete();
    exp_code  = 0;
    exp_words = 0;
    if ((c == 0) || (b + c > size)) begin
      exp_code = 1;
      exp_lat  = 2;
    end else begin
      exp_lat = 2 * c + 2;
      for (int k = 0; k < c; k++) begin
        idx = b + k;
        if (hb && (idx % 2 == 1) && (idx != (HB_TAPS - 1) / 2) && (src_words[k] != 0)) begin
          exp_code = 3;
          exp_lat  = 2 * k + 3;
          break;
        end
        if (stall) begin
          exp_code = 2;
          exp_lat  = 2 * k + 3 + TO;
          break;
        end
        addr = 8'(hb ? HB_BASE + idx : idx);
        sx   = 32'(int'(src_words[k]));
        exp_q.push_back({addr, sx});
        exp_words++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic hb, input logic [7:0] b, input logic [7:0] c);
    @(posedge clk);
    #1;
    sel_hb = hb; base_idx = b; count = c; start = 1'b1;
    t0 = cyc; valid_cycles = 0; first_valid_cyc = -1;
    @(posedge clk);
    #1;
    start = 1'b0; sel_hb = 1'b0; base_idx = 8'hFF; count = 8'hFF;
  endtask

  task automatic exec_load(input logic hb, input int b, input int c, input logic stall, input logic poke);
    int  n;
    logic seen;
    int  exp_valid;
    src_q.delete();
    for (int k = 0; k < c; k++) src_q.push_back(src_words[k]);
    bus_if.cfg_ready = !stall;
    start_cmd(hb, 8'(b), 8'(c));
    check("start_busy", 40'(busy), 40'd1);
    check("start_err_clr", 40'({error, error_type}), 40'd0);
    check("start_words_clr", 40'(words_written), 40'd0);
    n = 0;
    seen = 1'b0;
    while ((n < 600) && !seen) begin
      @(negedge clk);
      n++;
      if (poke && (n == 4)) begin
        start = 1'b1; sel_hb = 1'b1; base_idx = 8'd0; count = 8'd1;
      end else if (poke && (n == 5)) begin
        start = 1'b0;
      end
      if (done || error) begin
        seen = 1'b1;
        end_cyc = cyc;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL load_end: got no done/error within 600 cycles expected completion");
    end else begin
      check("end_done", 40'(done), 40'(exp_code == 0));
      check("end_error", 40'(error), 40'(exp_code != 0));
      check("end_busy", 40'(busy), 40'd0);
      check("latency", 40'(end_cyc - t0), 40'(exp_lat));
    end
    @(negedge clk);
    check("done_pulse", 40'(done), 40'd0);
    check("err_type", 40'(error_type), 40'(exp_code));
    check("err_sticky", 40'(error), 40'(exp_code != 0));
    check("words", 40'(words_written), 40'(exp_words));
    check("exp_drained", 40'(exp_q.size()), 40'd0);
    exp_valid = (exp_code == 2) ? TO : exp_words;
    check("valid_cycles", 40'(valid_cycles), 40'(exp_valid));
    if (exp_valid > 0) check("first_valid", 40'(first_valid_cyc - t0), 40'd3);
    src_q.delete();
    bus_if.cfg_ready = 1'b1;
  endtask

  task automatic wait_cfg_valid(input string name);
    int  n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while ((n < 50) && !seen) begin
      @(negedge clk);
      n++;
      if (bus_if.cfg_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: got no cfg_valid within 50 cycles expected cfg_valid", name);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {27'd0, bus_if.cfg_valid, bus_if.coeff_ready, busy, done, error, error_type, words_written},
          40'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    bus_if.cfg_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    check("reset_cfg_bus", {bus_if.cfg_addr, bus_if.cfg_data}, 40'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset_idle");

    // FIR base 0, four words including a negative one
    src_words[0] = 18'sd1; src_words[1] = 18'sd2; src_words[2] = 18'sd3; src_words[3] = -18'sd1;
    model_load(1'b0, 0, 4, 1'b0);
    check("pin_fir_w0", exp_q[0], {8'd0, 32'h00000001});
    check("pin_fir_w3", exp_q[3], {8'd3, 32'hFFFFFFFF});
    check("pin_fir_lat", 40'(exp_lat), 40'd10);
    exec_load(1'b0, 0, 4, 1'b0, 1'b0);
    check("fir_words_lit", 40'(words_written), 40'd4);

    // full halfband bank, odd taps zero, centre 0x10000
    for (int k = 0; k < 33; k++)
      src_words[k] = (k % 2 == 1) ? 18'sd0 : ((k == 16) ? 18'sh10000 : 18'(k * 100 - 700));
    model_load(1'b1, 0, 33, 1'b0);
    check("pin_hb_size", 40'(exp_q.size()), 40'd33);
    check("pin_hb_centre", exp_q[16], {8'd80, 32'h00010000});
    check("pin_hb_w0", exp_q[0], {8'd64, 32'hFFFFFD44});
    check("pin_hb_lat", 40'(exp_lat), 40'd68);
    exec_load(1'b1, 0, 33, 1'b0, 1'b0);

    // range: overflow past the bank end, zero count, exact fit, halfband overflow
    for (int k = 0; k < 8; k++) src_words[k] = 18'(k + 40);
    model_load(1'b0, 62, 4, 1'b0);
    check("pin_range_code", 40'(exp_code), 40'd1);
    exec_load(1'b0, 62, 4, 1'b0, 1'b0);
    model_load(1'b0, 0, 0, 1'b0);
    exec_load(1'b0, 0, 0, 1'b0, 1'b0);
    model_load(1'b0, 60, 4, 1'b0);
    check("pin_fit_code", 40'(exp_code), 40'd0);
    exec_load(1'b0, 60, 4, 1'b0, 1'b0);
    model_load(1'b1, 30, 4, 1'b0);
    exec_load(1'b1, 30, 4, 1'b0, 1'b0);

    // sink never ready: timeout
    src_words[0] = 18'sd7;
    model_load(1'b0, 0, 1, 1'b1);
    check("pin_to_lat", 40'(exp_lat), 40'd258);
    exec_load(1'b0, 0, 1, 1'b1, 1'b0);
    check("to_valid_lit", 40'(valid_cycles), 40'd255);
    check("to_words_lit", 40'(words_written), 40'd0);

    // halfband zero-tap violation at index 3
    for (int k = 0; k < 8; k++) src_words[k] = 18'sd0;
    src_words[0] = 18'sd10; src_words[2] = -18'sd7; src_words[3] = 18'sd5;
    model_load(1'b1, 0, 8, 1'b0);
    check("pin_sym_code", 40'(exp_code), 40'd3);
    check("pin_sym_words", 40'(exp_words), 40'd3);
    exec_load(1'b1, 0, 8, 1'b0, 1'b0);
    check("sym_words_lit", 40'(words_written), 40'd3);

    // abort while the sink stalls
    exp_q.delete();
    src_q.delete();
    src_q.push_back(18'd9);
    src_q.push_back(18'd10);
    bus_if.cfg_ready = 1'b0;
    start_cmd(1'b0, 8'd10, 8'd2);
    wait_cfg_valid("abort_wait");
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_flags", 40'({error, error_type, busy}), 40'({1'b1, 3'b100, 1'b0}));
    check("abort_words", 40'(words_written), 40'd0);
    check("abort_valid_drop", 40'(bus_if.cfg_valid), 40'd0);
    src_q.delete();
    bus_if.cfg_ready = 1'b1;

    // abort while idle leaves the sticky error untouched
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("idle_abort", 40'({error, error_type, busy}), 40'({1'b1, 3'b100, 1'b0}));

    // next load clears the error and completes; a start mid-load is ignored
    src_words[0] = 18'sd11; src_words[1] = -18'sd22; src_words[2] = 18'sd33;
    model_load(1'b0, 5, 3, 1'b0);
    exec_load(1'b0, 5, 3, 1'b0, 1'b1);

    // asynchronous reset in the middle of a load
    for (int k = 0; k < 3; k++) src_words[k] = 18'(k + 1);
    model_load(1'b0, 20, 3, 1'b0);
    for (int k = 0; k < 3; k++) src_q.push_back(src_words[k]);
    start_cmd(1'b0, 8'd20, 8'd3);
    begin
      int n;
      n = 0;
      while ((n < 50) && (words_written != 8'd2)) begin
        @(negedge clk);
        n++;
      end
      check("rst_mid_reached", 40'(words_written), 40'd2);
    end
    dc = done_count;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_outputs");
    exp_q.delete();
    src_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_done", 40'(done_count), 40'(dc));
    check("rst_no_error", 40'({error, error_type, busy}), 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by %0t expected finish", $time);
    $fatal(1, "watchdog");
  end
endmodule
